// File: rtl/apb4_mst_seq_pkg.sv
// -----------------------------------------------------------------------------
// apb4_mst_seq_pkg
// Shared definitions for the APB4 master sequencer: default parameter values
// and the transfer FSM state encoding.
//
// Optional feature macro used by this slice: APB4_MST_SEQ_TIMEOUT_EN
// (enables the ACCESS-phase wait limit; see apb4_mst_seq / apb4_mst_seq_tmo).
// -----------------------------------------------------------------------------
package apb4_mst_seq_pkg;

    localparam int unsigned DEF_ADDR_WIDTH     = 32;
    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 256;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/apb4_mst_seq_if.sv
// -----------------------------------------------------------------------------
// apb4_mst_seq_if
// Signal bundle for one apb4_mst_seq instance: the command channel, the
// response channel and the APB4 bus. The sequencer top keeps flat ports so
// it can be dropped into netlists without an interface; integrations and the
// bench use this bundle and wire its members to those ports.
//
// Modports:
//   master - the sequencer's view (drives cmd_ready, rsp_*, APB requests)
//   slave  - the environment's view (command source, response sink, APB slave)
//
// Handshake rule for both cmd and rsp channels: a transfer happens on a
// rising clock edge where valid and ready are both 1; the offering side holds
// valid and its payload stable until that edge.
// -----------------------------------------------------------------------------
interface apb4_mst_seq_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0] cmd_strb;
    logic [2:0]            cmd_prot;

    // response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_tmo;

    // APB4 bus
    logic [ADDR_WIDTH-1:0] paddr;
    logic [2:0]            pprot;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_WIDTH-1:0] pstrb;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
        input  rsp_ready,
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
        output rsp_ready,
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb4_mst_seq_tmo.sv
// -----------------------------------------------------------------------------
// apb4_mst_seq_tmo
// ACCESS-phase cycle counter. Only instantiated when APB4_MST_SEQ_TIMEOUT_EN
// is defined.
//
// Ports:
//   clk_i, rst_n_i - clock, asynchronous active-low reset
//   clr_i          - reload the count to 0 (asserted the cycle before ACCESS)
//   inc_i          - an ACCESS cycle is in progress
//   last_o         - the current ACCESS cycle is the final allowed one
//
// The count equals the number of ACCESS cycles already completed, so last_o
// is high during the TIMEOUT_CYCLES-th ACCESS cycle. The caller gives pready
// priority over last_o in that cycle.
// -----------------------------------------------------------------------------
module apb4_mst_seq_tmo #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic last_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = inc_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/apb4_mst_seq.sv
// -----------------------------------------------------------------------------
// apb4_mst_seq
// Single-outstanding APB4 master sequencer. Accepts one command, runs it as
// an APB SETUP + ACCESS transfer, then presents the result on the response
// channel until it is taken.
//
// Ports:
//   clk_i, rst_n_i               - clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o    - command handshake
//   cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i, cmd_prot_i - command
//   rsp_valid_o / rsp_ready_i    - response handshake
//   rsp_rdata_o, rsp_err_o, rsp_tmo_o                            - response
//   paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o - APB req
//   pready_i, prdata_i, pslverr_i                                - APB completion
//
// Handshake rule (cmd and rsp): transfer on a rising edge with valid and
// ready both 1; valid and payload stay stable until then.
//
// Macro APB4_MST_SEQ_TIMEOUT_EN: when defined, an ACCESS phase lasting
// TIMEOUT_CYCLES cycles without pready_i is abandoned and answered with
// rsp_err_o=1, rsp_tmo_o=1, rsp_rdata_o=0. When undefined ACCESS waits
// forever and rsp_tmo_o is 0.
// -----------------------------------------------------------------------------
module apb4_mst_seq
    import apb4_mst_seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,

    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
    input  logic [2:0]              cmd_prot_i,

    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_tmo_o,

    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [2:0]              pprot_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic                    pready_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pslverr_i
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    state_e state_q;
    state_e state_d;

    // Low during reset and for the first cycle after release, so cmd_ready_o
    // only rises once reset has been released.
    logic live_q;

    // Captured command
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] strb_q;
    logic [2:0]            prot_q;

    // Captured response
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic cmd_accept;
    logic access_done;
    logic tmo_hit;

    assign cmd_accept  = cmd_valid_i && (state_q == ST_IDLE) && live_q;
    assign access_done = (state_q == ST_ACCESS) && pready_i;

`ifdef APB4_MST_SEQ_TIMEOUT_EN
    logic tmo_q;
    logic tmo_last;

    apb4_mst_seq_tmo #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (state_q == ST_SETUP),
        .inc_i   (state_q == ST_ACCESS),
        .last_o  (tmo_last)
    );

    // pready_i on the final allowed cycle completes the transfer normally.
    assign tmo_hit = tmo_last && !pready_i;
`else
    assign tmo_hit = 1'b0;
    wire unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cmd_accept)               state_d = ST_SETUP;
            ST_SETUP:                                state_d = ST_ACCESS;
            ST_ACCESS: if (access_done || tmo_hit)   state_d = ST_RESP;
            ST_RESP:   if (rsp_ready_i)              state_d = ST_IDLE;
            default:                                 state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
        end else if (cmd_accept) begin
            wr_q    <= cmd_write_i;
            addr_q  <= cmd_addr_i;
            wdata_q <= cmd_wdata_i;
            // Reads never carry strobes onto the bus.
            strb_q  <= cmd_write_i ? cmd_strb_i : '0;
            prot_q  <= cmd_prot_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (access_done) begin
            rdata_q <= wr_q ? '0 : prdata_i;
            err_q   <= pslverr_i;
        end else if (tmo_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end
    end

`ifdef APB4_MST_SEQ_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_q <= 1'b0;
        end else if (access_done) begin
            tmo_q <= 1'b0;
        end else if (tmo_hit) begin
            tmo_q <= 1'b1;
        end
    end
`endif

    // -------------------------------------------------------------- outputs
    // Every output is gated by state so IDLE/RESP/reset leave the bus at 0
    // and the response channel at 0 outside RESP.
    always_comb begin
        logic on_bus;
        on_bus      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

        cmd_ready_o = live_q && (state_q == ST_IDLE);

        psel_o      = on_bus;
        penable_o   = (state_q == ST_ACCESS);
        paddr_o     = on_bus ? addr_q : '0;
        pprot_o     = on_bus ? prot_q : '0;
        pwrite_o    = on_bus && wr_q;
        pwdata_o    = (on_bus && wr_q) ? wdata_q : '0;
        pstrb_o     = on_bus ? strb_q : '0;

        rsp_valid_o = (state_q == ST_RESP);
        rsp_rdata_o = (state_q == ST_RESP) ? rdata_q : '0;
        rsp_err_o   = (state_q == ST_RESP) && err_q;
    end

`ifdef APB4_MST_SEQ_TIMEOUT_EN
    assign rsp_tmo_o = (state_q == ST_RESP) && tmo_q;
`else
    assign rsp_tmo_o = 1'b0;
`endif

endmodule
